// File: rtl/timer_programmable.sv
// Programmable down-counting event timer: runtime load value, compile-time prescaler,
// one-shot or periodic mode, pause via enable, abort, done pulse and sticky irq/overrun.
module timer_programmable #(
    parameter int unsigned WIDTH    = 8,
    parameter int unsigned PRESCALE = 1
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             enable,
    input  logic             start,
    input  logic             stop,
    input  logic [WIDTH-1:0] load_value,
    input  logic             mode,
    input  logic             clear_irq,
    output logic [WIDTH-1:0] count,
    output logic             busy,
    output logic             done,
    output logic             irq,
    output logic             overrun
);

    typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] count_q, count_d;
    logic [WIDTH-1:0] reload_q, reload_d;
    logic             mode_q, mode_d;
    logic             busy_q, done_q, done_d;
    logic             irq_q, irq_d, ovr_q, ovr_d;
    logic             psc_wrap;
    logic [WIDTH-1:0] load_eff;

    assign load_eff = (load_value == '0) ? WIDTH'(1) : load_value;

    // Prescaler: only exists when more than one clock per tick is needed.
    if (PRESCALE > 1) begin : g_psc
        localparam int unsigned PSC_W = $clog2(PRESCALE);
        logic [PSC_W-1:0] psc_q;

        assign psc_wrap = (psc_q == PSC_W'(PRESCALE - 1));

        always_ff @(posedge clk or negedge reset_n) begin
            if (!reset_n) begin
                psc_q <= '0;
            end else if (stop || start) begin
                psc_q <= '0;
            end else if (state_q == RUN && enable) begin
                psc_q <= psc_wrap ? '0 : psc_q + PSC_W'(1);
            end
        end
    end else begin : g_nopsc
        assign psc_wrap = 1'b1;
    end

    // State and output registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= IDLE;
            count_q  <= '0;
            reload_q <= '0;
            mode_q   <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            irq_q    <= 1'b0;
            ovr_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            count_q  <= count_d;
            reload_q <= reload_d;
            mode_q   <= mode_d;
            busy_q   <= (state_d == RUN);
            done_q   <= done_d;
            irq_q    <= irq_d;
            ovr_q    <= ovr_d;
        end
    end

    // Next-state: stop beats start beats tick; an expiry's set beats clear_irq.
    always_comb begin
        state_d  = state_q;
        count_d  = count_q;
        reload_d = reload_q;
        mode_d   = mode_q;
        done_d   = 1'b0;
        irq_d    = clear_irq ? 1'b0 : irq_q;
        ovr_d    = clear_irq ? 1'b0 : ovr_q;

        if (stop) begin
            state_d = IDLE;
            count_d = '0;
        end else if (start) begin
            state_d  = RUN;
            reload_d = load_eff;
            count_d  = load_eff;
            mode_d   = mode;
        end else if (state_q == RUN && enable && psc_wrap) begin
            if (count_q > WIDTH'(1)) begin
                count_d = count_q - WIDTH'(1);
            end else begin
                done_d = 1'b1;
                irq_d  = 1'b1;
                ovr_d  = ovr_d | irq_q;
                if (mode_q) begin
                    count_d = reload_q;
                end else begin
                    count_d = '0;
                    state_d = IDLE;
                end
            end
        end
    end

    assign count   = count_q;
    assign busy    = busy_q;
    assign done    = done_q;
    assign irq     = irq_q;
    assign overrun = ovr_q;

endmodule

// File: tb/tb_timer_programmable.sv
// Scoreboard bench for timer_programmable: three instances with PRESCALE 1, 2 and 4.
module tb_timer_programmable;

    typedef struct {
        int         inst;
        int         cyc;
        logic       irq;
        logic       ovr;
        logic [7:0] cnt;
        logic       busy;
    } exp_t;

    logic       clk = 1'b0;
    logic       reset_n;
    logic       en [3];
    logic       st [3];
    logic       sp [3];
    logic       md [3];
    logic       clr [3];
    logic [7:0] ld [3];
    logic [7:0] count_w [3];
    logic       busy_w [3];
    logic       done_w [3];
    logic       irq_w [3];
    logic       ovr_w [3];

    exp_t sb[$];
    int   cyc = 0;
    int   n_cmp = 0;
    int   n_err = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic on_done(input int i);
        exp_t e;
        if (sb.size() == 0) begin
            n_cmp++;
            n_err++;
            $display("FAIL stray_done: inst %0d got done=1 expected 0 (cycle %0d)", i, cyc);
        end else begin
            e = sb.pop_front();
            chk("done_inst", i, e.inst);
            chk("done_cycle", cyc, e.cyc);
            chk("done_irq", int'(irq_w[i]), int'(e.irq));
            chk("done_overrun", int'(ovr_w[i]), int'(e.ovr));
            chk("done_count", int'(count_w[i]), int'(e.cnt));
            chk("done_busy", int'(busy_w[i]), int'(e.busy));
        end
    endtask

    for (genvar g = 0; g < 3; g++) begin : g_dut
        timer_programmable #(.WIDTH(8), .PRESCALE(1 << g)) u_dut (
            .clk        (clk),
            .reset_n    (reset_n),
            .enable     (en[g]),
            .start      (st[g]),
            .stop       (sp[g]),
            .load_value (ld[g]),
            .mode       (md[g]),
            .clear_irq  (clr[g]),
            .count      (count_w[g]),
            .busy       (busy_w[g]),
            .done       (done_w[g]),
            .irq        (irq_w[g]),
            .overrun    (ovr_w[g])
        );

        // Monitor: every done pulse must match the next scoreboard entry.
        always @(negedge clk) if (done_w[g]) on_done(g);
    end

    task automatic wait_n(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic do_start(input int i, input logic [7:0] lv, input logic m, output int e0);
        ld[i] = lv;
        md[i] = m;
        st[i] = 1'b1;
        e0    = cyc + 1;
        @(negedge clk);
        st[i] = 1'b0;
    endtask

    task automatic clear_pulse(input int i);
        clr[i] = 1'b1;
        @(negedge clk);
        clr[i] = 1'b0;
    endtask

    task automatic push(input int i, input int c, input logic q, input logic o,
                        input logic [7:0] n, input logic b);
        exp_t e;
        e.inst = i; e.cyc = c; e.irq = q; e.ovr = o; e.cnt = n; e.busy = b;
        sb.push_back(e);
    endtask

    task automatic chk_idle(input string name, input int i);
        chk({name, "_count"}, int'(count_w[i]), 0);
        chk({name, "_busy"}, int'(busy_w[i]), 0);
        chk({name, "_done"}, int'(done_w[i]), 0);
        chk({name, "_irq"}, int'(irq_w[i]), 0);
        chk({name, "_overrun"}, int'(ovr_w[i]), 0);
    endtask

    initial begin
        int e0;
        int e1;
        reset_n = 1'b0;
        for (int i = 0; i < 3; i++) begin
            en[i] = 1'b1; st[i] = 1'b0; sp[i] = 1'b0;
            md[i] = 1'b0; clr[i] = 1'b0; ld[i] = 8'd0;
        end
        wait_n(2);
        for (int i = 0; i < 3; i++) chk_idle("reset", i);
        reset_n = 1'b1;
        wait_n(2);

        // One-shot L=5, PRESCALE=4: done 20 cycles after start.
        do_start(2, 8'd5, 1'b0, e0);
        push(2, e0 + 20, 1'b1, 1'b0, 8'd0, 1'b0);
        wait_n(25);
        chk("oneshot_busy", int'(busy_w[2]), 0);
        chk("oneshot_count", int'(count_w[2]), 0);
        chk("oneshot_irq", int'(irq_w[2]), 1);

        // Periodic L=3, PRESCALE=1: done at 3, 6, 9; overrun from the second expiry.
        do_start(0, 8'd3, 1'b1, e0);
        chk("periodic_load_count", int'(count_w[0]), 3);
        push(0, e0 + 3, 1'b1, 1'b0, 8'd3, 1'b1);
        push(0, e0 + 6, 1'b1, 1'b1, 8'd3, 1'b1);
        push(0, e0 + 9, 1'b1, 1'b1, 8'd3, 1'b1);
        wait_n(9);
        clear_pulse(0);
        chk("clear_irq", int'(irq_w[0]), 0);
        chk("clear_overrun", int'(ovr_w[0]), 0);
        chk("periodic_running_count", int'(count_w[0]), 2);
        sp[0] = 1'b1;
        @(negedge clk);
        sp[0] = 1'b0;
        chk("stop_busy", int'(busy_w[0]), 0);
        chk("stop_count", int'(count_w[0]), 0);
        wait_n(5);

        // One-shot L=10 with a 4-cycle enable gap: done 14 cycles after start.
        do_start(0, 8'd10, 1'b0, e0);
        push(0, e0 + 14, 1'b1, 1'b0, 8'd0, 1'b0);
        wait_n(3);
        en[0] = 1'b0;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            chk("gap_count_frozen", int'(count_w[0]), 7);
        end
        chk("gap_busy", int'(busy_w[0]), 1);
        en[0] = 1'b1;
        wait_n(10);

        // load_value=0 at PRESCALE=2 acts as 1; then restart after one cycle of an L=4 run.
        do_start(1, 8'd0, 1'b0, e0);
        push(1, e0 + 2, 1'b1, 1'b0, 8'd0, 1'b0);
        wait_n(3);
        clear_pulse(1);
        do_start(1, 8'd4, 1'b0, e0);
        @(negedge clk);
        do_start(1, 8'd4, 1'b0, e1);
        chk("restart_count", int'(count_w[1]), 4);
        push(1, e1 + 8, 1'b1, 1'b0, 8'd0, 1'b0);
        wait_n(12);

        // Stop on the expiry edge, then start+stop together.
        clear_pulse(0);
        do_start(0, 8'd3, 1'b0, e0);
        wait_n(2);
        sp[0] = 1'b1;
        @(negedge clk);
        sp[0] = 1'b0;
        chk_idle("stop_on_expiry", 0);
        st[0] = 1'b1;
        sp[0] = 1'b1;
        @(negedge clk);
        st[0] = 1'b0;
        sp[0] = 1'b0;
        chk_idle("start_and_stop", 0);
        wait_n(5);

        // Asynchronous reset mid-run clears everything immediately.
        do_start(2, 8'd3, 1'b1, e0);
        wait_n(5);
        #1 reset_n = 1'b0;
        #1;
        chk_idle("async_reset", 2);
        @(negedge clk);
        reset_n = 1'b1;
        wait_n(30);
        chk("post_reset_busy", int'(busy_w[2]), 0);

        while (sb.size() > 0) begin
            exp_t e;
            e = sb.pop_front();
            n_cmp++;
            n_err++;
            $display("FAIL missing_done: inst %0d got no done expected one at cycle %0d", e.inst, e.cyc);
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
